// File: rtl/hamming_enc_stream_if.sv
// Stream bundle for the Hamming encoder: data words in, codewords out, delivery count.
// The encoder takes the slave view and the traffic source/sink takes the master view.
interface hamming_enc_stream_if #(
  parameter int IP_BIT = 11
);
  localparam int CW = IP_BIT + 4;

  logic              in_valid;
  logic [IP_BIT-1:0] in_data;
  logic [3:0]        in_inj_pos;
  logic              in_ready;
  logic              out_valid;
  logic [CW-1:0]     out_code;
  logic              out_ready;
  logic [15:0]       word_cnt;

  modport slave (
    input  in_valid, in_data, in_inj_pos, out_ready,
    output in_ready, out_valid, out_code, word_cnt
  );

  modport master (
    output in_valid, in_data, in_inj_pos, out_ready,
    input  in_ready, out_valid, out_code, word_cnt
  );
endinterface

// File: rtl/hamming_enc_stream.sv
// Streaming Hamming(IP_BIT+4, IP_BIT) encoder: input FIFO, registered codeword output,
// optional single-bit error injection per word. Codeword position 1 is the MSB.
module hamming_enc_stream #(
  parameter int IP_BIT = 11,
  parameter int DEPTH  = 4
) (
  input logic                    clk,
  input logic                    rst,
  hamming_enc_stream_if.slave    bus
);
  localparam int CW   = IP_BIT + 4;
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [IP_BIT-1:0] data;
    logic [3:0]        inj;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic              out_valid_q, out_valid_d;
  logic [CW-1:0]     out_code_q, out_code_d;
  logic [15:0]       word_cnt_q, word_cnt_d;

  logic              in_ready;
  logic              push;
  logic              pop;
  entry_t            head;
  logic [CW-1:0]     enc_code;
  logic [CW-1:0]     inj_mask;
  logic [3:0][CW:1]  contrib;
  logic [3:0]        parity;

  assign in_ready = (count_q < CNTW'(DEPTH));
  assign push     = bus.in_valid && in_ready;
  assign pop      = (count_q != '0) && (!out_valid_q || bus.out_ready);
  assign head     = mem_q[rd_ptr_q];

  // Position p is data when p is not a power of two; its data index counts down from the MSB.
  for (genvar p = 1; p <= CW; p++) begin : g_pos
    if ((p & (p - 1)) != 0) begin : g_data
      localparam int DI = IP_BIT - p + $clog2(p);
      assign enc_code[CW-p] = head.data[DI];
      for (genvar k = 0; k < 4; k++) begin : g_cov
        if (((p >> k) & 1) == 1) begin : g_on
          assign contrib[k][p] = head.data[DI];
        end else begin : g_off
          assign contrib[k][p] = 1'b0;
        end
      end
    end else begin : g_par
      assign enc_code[CW-p] = parity[$clog2(p)];
      for (genvar k = 0; k < 4; k++) begin : g_cov
        assign contrib[k][p] = 1'b0;
      end
    end
    // Injection positions of 0 or beyond CW match no bit, so they leave the word intact.
    assign inj_mask[CW-p] = (head.inj == 4'(p));
  end

  for (genvar k = 0; k < 4; k++) begin : g_parity
    assign parity[k] = ^contrib[k];
  end

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    word_cnt_d  = word_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase

    if (pop) begin
      out_valid_d = 1'b1;
      out_code_d  = enc_code ^ inj_mask;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (out_valid_q && bus.out_ready) word_cnt_d = word_cnt_q + 16'd1;
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      word_cnt_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  // NOTE: FIFO storage is not reset; an empty count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.in_data, bus.in_inj_pos};
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_code  = out_code_q;
  assign bus.word_cnt  = word_cnt_q;
endmodule

// File: tb/tb_hamming_enc_stream.sv
// Scoreboard bench for hamming_enc_stream: directed cases plus random traffic on an
// 11-bit/DEPTH=4 instance and a 7-bit/DEPTH=2 instance, checked against a syndrome model.
module tb_hamming_enc_stream;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hamming_enc_stream_if #(.IP_BIT(11)) b11 ();
  hamming_enc_stream_if #(.IP_BIT(7))  b7  ();

  hamming_enc_stream #(.IP_BIT(11), .DEPTH(4)) dut11 (.clk(clk), .rst(rst), .bus(b11));
  hamming_enc_stream #(.IP_BIT(7),  .DEPTH(2)) dut7  (.clk(clk), .rst(rst), .bus(b7));

  typedef struct {
    logic [10:0] data;
    logic [3:0]  inj;
    logic [14:0] code;
  } exp_t;

  exp_t        q11[$];
  exp_t        q7[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] cnt11 = '0;
  logic [15:0] cnt7  = '0;
  bit          stall11 = 0;
  bit          stall7  = 0;
  logic [14:0] held11 = '0;
  logic [14:0] held7  = '0;
  bit          rand_ready = 0;
  logic [10:0] words [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Parity bits are chosen so the XOR of the positions of all set bits is zero.
  function automatic logic [14:0] m_encode(input int db, input logic [10:0] data, input logic [3:0] inj);
    int          n = db + 4;
    int          syn = 0;
    int          di = db - 1;
    bit          cw [16];
    logic [14:0] code = '0;
    for (int p = 0; p < 16; p++) cw[p] = 0;
    for (int p = 1; p <= n; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = data[di];
        di--;
        if (cw[p]) syn ^= p;
      end
    end
    for (int k = 0; k < 4; k++) cw[1 << k] = syn[k];
    if (inj != 0 && int'(inj) <= n) cw[inj] = !cw[inj];
    for (int p = 1; p <= n; p++) code[n-p] = cw[p];
    return code;
  endfunction

  function automatic int m_syndrome(input int db, input logic [14:0] code);
    int n = db + 4;
    int s = 0;
    for (int p = 1; p <= n; p++) if (code[n-p]) s ^= p;
    return s;
  endfunction

  function automatic logic [10:0] m_decode(input int db, input logic [14:0] code);
    int          n = db + 4;
    int          s = m_syndrome(db, code);
    int          di = db - 1;
    logic [14:0] c = code;
    logic [10:0] d = '0;
    if (s != 0 && s <= n) c[n-s] = !c[n-s];
    for (int p = 1; p <= n; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[di] = c[n-p];
        di--;
      end
    end
    return d;
  endfunction

  function automatic int exp_syn(input int db, input logic [3:0] inj);
    return (inj != 0 && int'(inj) <= db + 4) ? int'(inj) : 0;
  endfunction

  // Input monitors: every accepted word becomes an expected codeword.
  always @(negedge clk) begin
    if (!rst && b11.in_valid && b11.in_ready)
      q11.push_back('{b11.in_data, b11.in_inj_pos, m_encode(11, b11.in_data, b11.in_inj_pos)});
    if (!rst && b7.in_valid && b7.in_ready)
      q7.push_back('{11'(b7.in_data), b7.in_inj_pos, m_encode(7, 11'(b7.in_data), b7.in_inj_pos)});
  end

  always @(negedge clk) begin : mon11
    exp_t e;
    if (!rst) begin
      check("word_cnt11", b11.word_cnt, cnt11);
      if (stall11) begin
        check("hold_valid11", b11.out_valid, 1);
        check("hold_code11", b11.out_code, held11);
      end
      if (b11.out_valid && b11.out_ready) begin
        if (q11.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL spurious11: got %h, want no output", b11.out_code);
        end else begin
          e = q11.pop_front();
          check("code11", b11.out_code, e.code);
          check("decode11", m_decode(11, b11.out_code), e.data);
          check("syndrome11", m_syndrome(11, b11.out_code), exp_syn(11, e.inj));
        end
        cnt11 = cnt11 + 16'd1;
      end
      stall11 = b11.out_valid && !b11.out_ready;
      held11  = b11.out_code;
    end
  end

  always @(negedge clk) begin : mon7
    exp_t e;
    if (!rst) begin
      check("word_cnt7", b7.word_cnt, cnt7);
      if (stall7) begin
        check("hold_valid7", b7.out_valid, 1);
        check("hold_code7", 15'(b7.out_code), held7);
      end
      if (b7.out_valid && b7.out_ready) begin
        if (q7.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL spurious7: got %h, want no output", b7.out_code);
        end else begin
          e = q7.pop_front();
          check("code7", 15'(b7.out_code), e.code);
          check("decode7", m_decode(7, 15'(b7.out_code)), e.data);
          check("syndrome7", m_syndrome(7, 15'(b7.out_code)), exp_syn(7, e.inj));
        end
        cnt7 = cnt7 + 16'd1;
      end
      stall7 = b7.out_valid && !b7.out_ready;
      held7  = 15'(b7.out_code);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) begin
        b11.out_ready = ($urandom_range(0, 3) != 0);
        b7.out_ready  = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the word is accepted.
  task automatic send11(input logic [10:0] d, input logic [3:0] inj);
    int waited = 0;
    b11.in_valid = 1'b1; b11.in_data = d; b11.in_inj_pos = inj;
    do begin @(negedge clk); waited++; end while (!b11.in_ready && waited < 300);
    if (!b11.in_ready) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout11: got in_ready=0, want 1");
    end
    @(posedge clk); #1;
  endtask

  task automatic send7(input logic [6:0] d, input logic [3:0] inj);
    int waited = 0;
    b7.in_valid = 1'b1; b7.in_data = d; b7.in_inj_pos = inj;
    do begin @(negedge clk); waited++; end while (!b7.in_ready && waited < 300);
    if (!b7.in_ready) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout7: got in_ready=0, want 1");
    end
    @(posedge clk); #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;
    rst = 1'b1;
    b11.in_valid = 1'b0; b11.in_data = '0; b11.in_inj_pos = '0; b11.out_ready = 1'b1;
    b7.in_valid  = 1'b0; b7.in_data  = '0; b7.in_inj_pos  = '0; b7.out_ready  = 1'b1;
    cycles(2);
    check("rst_in_ready", b11.in_ready, 1);
    check("rst_out_valid", b11.out_valid, 0);
    check("rst_out_code", b11.out_code, 0);
    check("rst_word_cnt", b11.word_cnt, 0);
    rst = 1'b0;
    cycles(1);

    // Single word: visible one edge after acceptance.
    send11(11'h001, 4'd0);
    b11.in_valid = 1'b0;
    check("latency_early", b11.out_valid, 0);
    cycles(1);
    check("first_valid", b11.out_valid, 1);
    check("first_code", b11.out_code, 15'h6881);
    cycles(1);
    check("first_cnt", b11.word_cnt, 1);
    check("first_drain", b11.out_valid, 0);

    // Back-to-back words stream without a bubble.
    send11(11'h400, 4'd0);
    send11(11'h000, 4'd0);
    b11.in_valid = 1'b0;
    check("b2b_code0", b11.out_code, 15'h7000);
    check("b2b_valid0", b11.out_valid, 1);
    cycles(1);
    check("b2b_code1", b11.out_code, 15'h0000);
    check("b2b_valid1", b11.out_valid, 1);
    cycles(1);
    check("b2b_idle", b11.out_valid, 0);

    // Backpressure: one word in the output register plus DEPTH in the FIFO.
    b11.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) words[i] = 11'($urandom_range(0, 2047));
    for (int i = 0; i < 5; i++) send11(words[i], 4'd0);
    check("full_in_ready", b11.in_ready, 0);
    check("full_code", b11.out_code, m_encode(11, words[0], 4'd0));
    b11.in_valid = 1'b1; b11.in_data = words[5]; b11.in_inj_pos = 4'd0;
    cycles(3);
    check("full_hold_ready", b11.in_ready, 0);
    check("full_hold_code", b11.out_code, m_encode(11, words[0], 4'd0));
    b11.out_ready = 1'b1;
    send11(words[5], 4'd0);
    b11.in_valid = 1'b0;
    waited = 0;
    while (q11.size() != 0 && waited < 50) begin cycles(1); waited++; end
    cycles(2);
    check("bp_drained", q11.size(), 0);
    check("bp_word_cnt", b11.word_cnt, 9);

    // Injection at the last position flips the LSB.
    send11(11'h001, 4'd15);
    b11.in_valid = 1'b0;
    cycles(1);
    check("inj_code", b11.out_code, 15'h6880);
    check("inj_decode", m_decode(11, b11.out_code), 11'h001);
    cycles(2);

    // Reset with the output register full and the FIFO half full.
    b11.out_ready = 1'b0;
    send11(11'h123, 4'd0);
    send11(11'h456, 4'd3);
    send11(11'h789, 4'd0);
    b11.in_valid = 1'b0;
    rst = 1'b1;
    q11.delete();
    cnt11 = '0;
    stall11 = 0;
    #1;
    check("mid_rst_valid", b11.out_valid, 0);
    check("mid_rst_ready", b11.in_ready, 1);
    check("mid_rst_cnt", b11.word_cnt, 0);
    cycles(2);
    rst = 1'b0;
    b11.out_ready = 1'b1;
    send11(11'h2AB, 4'd0);
    b11.in_valid = 1'b0;
    cycles(1);
    check("post_rst_first", b11.out_code, m_encode(11, 11'h2AB, 4'd0));
    cycles(2);

    // Random traffic on both widths concurrently.
    rand_ready = 1;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 1) == 1) begin
            b11.in_valid = 1'b0;
            cycles($urandom_range(1, 2));
          end
          send11(11'($urandom_range(0, 2047)),
                 ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15)));
        end
        b11.in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 1) == 1) begin
            b7.in_valid = 1'b0;
            cycles($urandom_range(1, 2));
          end
          send7(7'($urandom_range(0, 127)),
                ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15)));
        end
        b7.in_valid = 1'b0;
      end
    join
    rand_ready = 0;
    @(posedge clk); #2;
    b11.out_ready = 1'b1;
    b7.out_ready  = 1'b1;
    waited = 0;
    while ((q11.size() != 0 || q7.size() != 0) && waited < 200) begin cycles(1); waited++; end
    cycles(3);
    check("final_drain11", q11.size(), 0);
    check("final_drain7", q7.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
